shift_unit: RTL

Parametrised, multi-cycle shift unit for the pipelined MIPS datapath, replacing fixed-amount shifters with one block that performs logical-left, logical-right, arithmetic-right and rotate-left by a variable amount. It shifts at most STEP bit positions per clock, trading latency for a narrow shifter. It sits beside the ALU in EX, and the hazard unit stalls the pipeline while Busy is high.

---
 rtl/shift_pkg.sv | 14 +
 rtl/shift_step.sv | 27 ++
 rtl/shift_unit.sv | 95 +++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift unit: operation codes and FSM states.
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One bounded step of the iterative shifter: shifts acc by k (0..STEP) per the op.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic [WIDTH-1:0]             acc,
    input  logic [$clog2(STEP+1)-1:0]    k,
    input  logic [1:0]                   op,
    output logic [WIDTH-1:0]             res
);

    // Select the shifted value; ROL with k=0 degenerates cleanly because a
    // shift by WIDTH yields zero.
    always_comb begin
        res = acc;
        case (op)
            OP_SLL:  res = acc << k;
            OP_SRL:  res = acc >> k;
            OP_SRA:  res = $signed(acc) >>> k;
            OP_ROL:  res = (acc << k) | (acc >> (WIDTH - int'(k)));
            default: res = acc;
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Multi-cycle variable shifter (SLL/SRL/SRA/ROL) moving at most STEP bits per clock.
// Busy stalls the pipeline; Done pulses for one cycle when Out is refreshed.
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int STEP    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   out
);

    localparam int KW = $clog2(STEP + 1);
    localparam int CW = (SHAMT_W > KW) ? SHAMT_W : KW;

    state_t             state_r;
    logic [WIDTH-1:0]   acc_r;
    logic [SHAMT_W-1:0] rem_r;
    logic [1:0]         op_r;

    logic [CW-1:0]      rem_w_s;
    logic [KW-1:0]      k_s;
    logic               last_s;
    logic [WIDTH-1:0]   step_res_s;

    // Step size is min(rem, STEP); the step that brings rem within reach finishes.
    always_comb begin
        rem_w_s = CW'(rem_r);
        if (rem_w_s > CW'(STEP)) begin
            k_s = KW'(STEP);
        end else begin
            k_s = KW'(rem_w_s);
        end
        last_s = (rem_w_s <= CW'(STEP));
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .acc (acc_r),
        .k   (k_s),
        .op  (op_r),
        .res (step_res_s)
    );

    // Control FSM plus datapath registers; all outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            out     <= {WIDTH{1'b0}};
            acc_r   <= {WIDTH{1'b0}};
            rem_r   <= {SHAMT_W{1'b0}};
            op_r    <= 2'b00;
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        acc_r   <= in;
                        rem_r   <= shamt;
                        op_r    <= op;
                        busy    <= 1'b1;
                        state_r <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_r <= step_res_s;
                    rem_r <= rem_r - SHAMT_W'(k_s);
                    if (last_s) begin
                        out     <= step_res_s;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
